// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: FETCH/DECODE/EXE/MEM/WB sequencing.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN: unsupported instructions trap into HALT.
module mc_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] ext_op,
    output logic       alu_srcb,
    output logic [1:0] alu_op,
    output logic       mem_wr,
    output logic [2:0] state,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [2:0] MEM_LAST = 3'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_mem_cnt;

    logic w_rtype, w_addu, w_subu, w_jr, w_j, w_jal, w_beq;
    logic w_ori, w_lui, w_lw, w_sw, w_supported, w_mem_last;

    assign w_rtype     = (opcode == OP_RTYPE);
    assign w_addu      = w_rtype && (funct == FN_ADDU);
    assign w_subu      = w_rtype && (funct == FN_SUBU);
    assign w_jr        = w_rtype && (funct == FN_JR);
    assign w_j         = (opcode == OP_J);
    assign w_jal       = (opcode == OP_JAL);
    assign w_beq       = (opcode == OP_BEQ);
    assign w_ori       = (opcode == OP_ORI);
    assign w_lui       = (opcode == OP_LUI);
    assign w_lw        = (opcode == OP_LW);
    assign w_sw        = (opcode == OP_SW);
    assign w_supported = w_addu | w_subu | w_jr | w_j | w_jal | w_beq |
                         w_ori | w_lui | w_lw | w_sw;
    assign w_mem_last  = (r_mem_cnt == MEM_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_mem_cnt <= '0;
        end else begin
            r_state <= w_next;
            // Counter idles at zero outside MEM, so it is already cleared on entry.
            if (r_state == S_MEM && !w_mem_last)
                r_mem_cnt <= r_mem_cnt + 3'd1;
            else
                r_mem_cnt <= '0;
        end
    end

    assign state = r_state;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next     = S_FETCH;
        pc_wr      = 1'b0;
        pc_src     = 2'd0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        ext_op     = 2'd0;
        alu_srcb   = 1'b0;
        alu_op     = 2'd0;
        mem_wr     = 1'b0;
        instr_done = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_wr  = 1'b1;
                pc_wr  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    pc_wr      = 1'b1;
                    pc_src     = 2'd2;
                    instr_done = 1'b1;
                    if (w_jal) begin
                        reg_wr  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end
                end else if (w_jr) begin
                    pc_wr      = 1'b1;
                    pc_src     = 2'd3;
                    instr_done = 1'b1;
                end else if (w_supported) begin
                    w_next = S_EXE;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    instr_done = 1'b1;
`endif
                end
            end
            S_EXE: begin
                if (w_lw || w_sw) begin
                    ext_op   = 2'd1;
                    alu_srcb = 1'b1;
                    w_next   = S_MEM;
                end else if (w_beq) begin
                    alu_op     = 2'd1;
                    ext_op     = 2'd1;
                    pc_src     = 2'd1;
                    pc_wr      = zero;
                    instr_done = 1'b1;
                end else if (w_ori) begin
                    alu_srcb = 1'b1;
                    alu_op   = 2'd2;
                    w_next   = S_WB;
                end else if (w_lui) begin
                    ext_op   = 2'd2;
                    alu_srcb = 1'b1;
                    w_next   = S_WB;
                end else begin
                    alu_op = w_subu ? 2'd1 : 2'd0;
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (!w_mem_last) begin
                    w_next = S_MEM;
                end else if (w_sw) begin
                    mem_wr     = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
                if (w_lw)
                    wd_sel = 2'd1;
                else if (w_rtype)
                    reg_dst = 2'd1;
            end
            S_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                w_next = S_HALT;
`else
                w_next = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase

        // While reset is held the FETCH enables must not reach the datapath.
        if (!reset) begin
            pc_wr      = 1'b0;
            pc_src     = 2'd0;
            ir_wr      = 1'b0;
            reg_wr     = 1'b0;
            reg_dst    = 2'd0;
            wd_sel     = 2'd0;
            ext_op     = 2'd0;
            alu_srcb   = 1'b0;
            alu_op     = 2'd0;
            mem_wr     = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl (MEM_WAIT=2): stimulus queues per-cycle expected controls,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic [1:0] ext_op;
        logic       alu_srcb;
        logic [1:0] alu_op;
        logic       mem_wr;
        logic       done;
    } ctl_t;

    typedef struct {
        ctl_t  e;
        string tag;
    } sb_item_t;

    logic       clk, reset, zero;
    logic [5:0] opcode, funct;
    logic       pc_wr, ir_wr, reg_wr, alu_srcb, mem_wr, instr_done;
    logic [1:0] pc_src, reg_dst, wd_sel, ext_op, alu_op;
    logic [2:0] state;

    sb_item_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .ext_op(ext_op), .alu_srcb(alu_srcb),
        .alu_op(alu_op), .mem_wr(mem_wr), .state(state), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t v(input int st, input int pw, input int ps, input int iw,
                               input int rw, input int rd, input int ws, input int eo,
                               input int sbm, input int ao, input int mw, input int dn);
        ctl_t r;
        r.st = 3'(st);       r.pc_wr = 1'(pw);    r.pc_src = 2'(ps);
        r.ir_wr = 1'(iw);    r.reg_wr = 1'(rw);   r.reg_dst = 2'(rd);
        r.wd_sel = 2'(ws);   r.ext_op = 2'(eo);   r.alu_srcb = 1'(sbm);
        r.alu_op = 2'(ao);   r.mem_wr = 1'(mw);   r.done = 1'(dn);
        return r;
    endfunction

    task automatic check(input ctl_t exp, input string tag);
        ctl_t act;
        act = {state, pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wd_sel, ext_op,
               alu_srcb, alu_op, mem_wr, instr_done};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: one expected vector per clock cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            check(it.e, it.tag);
        end
    end

    task automatic cyc(input ctl_t e, input string tag);
        sb_item_t it;
        it.e = e;
        it.tag = tag;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] o, input logic [5:0] f, input logic z);
        opcode = o;
        funct  = f;
        zero   = z;
    endtask

    ctl_t cz, cf, cd, wb_r, wb_i, wb_lw, m0;

    initial begin
        cz    = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cf    = v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cd    = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_r  = v(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        wb_i  = v(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        wb_lw = v(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        m0    = v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        set_ir(6'b000000, 6'b000000, 1'b0);
        @(posedge clk);
        #1;
        cyc(cz, "reset_state");
        reset = 1'b1;

        set_ir(6'b000000, 6'b100001, 1'b1);
        cyc(cf, "addu_fetch");  cyc(cd, "addu_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addu_exe");
        cyc(wb_r, "addu_wb");

        set_ir(6'b000000, 6'b100011, 1'b0);
        cyc(cf, "subu_fetch");  cyc(cd, "subu_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "subu_exe");
        cyc(wb_r, "subu_wb");

        set_ir(6'b001101, 6'b000000, 1'b0);
        cyc(cf, "ori_fetch");   cyc(cd, "ori_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0), "ori_exe");
        cyc(wb_i, "ori_wb");

        set_ir(6'b001111, 6'b000000, 1'b1);
        cyc(cf, "lui_fetch");   cyc(cd, "lui_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), "lui_exe");
        cyc(wb_i, "lui_wb");

        set_ir(6'b100011, 6'b000000, 1'b0);
        cyc(cf, "lw_fetch");    cyc(cd, "lw_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "lw_exe");
        cyc(m0, "lw_mem0");     cyc(m0, "lw_mem1");     cyc(m0, "lw_mem2");
        cyc(wb_lw, "lw_wb");

        set_ir(6'b101011, 6'b000000, 1'b0);
        cyc(cf, "sw_fetch");    cyc(cd, "sw_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "sw_exe");
        cyc(m0, "sw_mem0");     cyc(m0, "sw_mem1");
        cyc(v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "sw_mem_last");

        set_ir(6'b000100, 6'b000000, 1'b1);
        cyc(cf, "beq1_fetch");  cyc(cd, "beq1_decode");
        cyc(v(2, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1), "beq_taken_exe");

        set_ir(6'b000100, 6'b000000, 1'b0);
        cyc(cf, "beq0_fetch");  cyc(cd, "beq0_decode");
        cyc(v(2, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1), "beq_not_taken_exe");

        set_ir(6'b000010, 6'b000000, 1'b0);
        cyc(cf, "j_fetch");
        cyc(v(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1), "j_decode");

        set_ir(6'b000011, 6'b000000, 1'b0);
        cyc(cf, "jal_fetch");
        cyc(v(1, 1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 1), "jal_decode");

        set_ir(6'b000000, 6'b001000, 1'b0);
        cyc(cf, "jr_fetch");
        cyc(v(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1), "jr_decode");

        // Reset asserted mid-cycle during lw MEM, no clock edge before the monitor samples.
        set_ir(6'b100011, 6'b000000, 1'b0);
        cyc(cf, "lwrst_fetch"); cyc(cd, "lwrst_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "lwrst_exe");
        cyc(m0, "lwrst_mem0");
        reset = 1'b0;
        cyc(cz, "reset_in_mem");
        reset = 1'b1;

        set_ir(6'b000000, 6'b100001, 1'b0);
        cyc(cf, "post_rst_fetch"); cyc(cd, "post_rst_decode");
        cyc(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_exe");
        cyc(wb_r, "post_rst_wb");

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        set_ir(6'b111111, 6'b000000, 1'b0);
        cyc(cf, "ill_fetch");
        cyc(cd, "ill_decode_trap");
        for (int i = 0; i < 22; i++)
            cyc(v(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_hold");
        reset = 1'b0;
        cyc(cz, "halt_reset");
        reset = 1'b1;
        cyc(cf, "halt_exit_fetch");
`else
        set_ir(6'b000000, 6'b100000, 1'b0);
        cyc(cf, "badfn_fetch");
        cyc(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "badfn_nop_decode");

        set_ir(6'b111111, 6'b000000, 1'b0);
        cyc(cf, "ill_fetch");
        cyc(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_nop_decode");
        cyc(cf, "ill_back_to_fetch");
`endif

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
